// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: arbiter state encoding
// and the default byte width handed to the transmitter.
package uart_pkg;

    // Default width of one byte sent to the UART transmitter.
    localparam int DEFAULT_DATA_WIDTH = 8;

    // Arbiter FSM state encoding, kept as plain constants so legacy
    // transmitter-side code can compare against the same values.
    localparam logic [1:0] ARB_IDLE      = 2'b00;
    localparam logic [1:0] ARB_LAUNCH    = 2'b01;
    localparam logic [1:0] ARB_WAIT_BUSY = 2'b10;
    localparam logic [1:0] ARB_WAIT_DONE = 2'b11;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: returns the first set request at or
// above rr_ptr, wrapping around, plus a flag saying any request is set.
// Generic enough to front any shared-resource arbiter.
module rr_priority_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic [$clog2(NUM_REQ)-1:0] winner,
    output logic                       any_req
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0] idx;

    // Scan upward from rr_ptr with wrap-around and keep the first hit.
    always_comb begin
        // NOTE: every output gets a default before the loop, so no path
        // leaves a value unassigned and no latch is inferred.
        winner  = '0;
        any_req = 1'b0;
        idx     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = PTR_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                winner  = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte
// sources. Grants one byte, launches it with a single-cycle valid, then
// follows the transmitter busy flag until the frame ends before granting
// again. A launch that never sees busy rise is dropped with timeout_err.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            ack,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic                          tx_data_valid,
    input  logic                          tx_busy,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          active,
    output logic                          timeout_err
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

    logic [1:0]            state;
    logic [PTR_W-1:0]      rr_ptr;
    logic [CNT_W-1:0]      busy_cnt;

    logic [PTR_W-1:0]      winner;
    logic                  any_req;
    logic [NUM_REQ-1:0]    win_onehot;
    logic [DATA_WIDTH-1:0] win_byte;
    logic [PTR_W-1:0]      next_ptr;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    // Decode the winner into its ack bit, its byte and the pointer after it.
    always_comb begin
        win_onehot = NUM_REQ'(1) << winner;
        win_byte   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (PTR_W'(i) == winner) begin
                win_byte = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        next_ptr = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + PTR_W'(1);
    end

    // Arbitration FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ARB_IDLE;
            rr_ptr        <= '0;
            busy_cnt      <= '0;
            ack           <= '0;
            tx_data       <= '0;
            tx_data_valid <= 1'b0;
            grant_id      <= '0;
            active        <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values; the defaults below make the pulses one cycle.
            ack           <= '0;
            tx_data_valid <= 1'b0;
            timeout_err   <= 1'b0;

            case (state)
                ARB_IDLE: begin
                    // A frame still on the line (busy high) blocks any grant.
                    if (any_req && !tx_busy) begin
                        ack      <= win_onehot;
                        tx_data  <= win_byte;
                        grant_id <= winner;
                        rr_ptr   <= next_ptr;
                        state    <= ARB_LAUNCH;
                    end
                end

                ARB_LAUNCH: begin
                    tx_data_valid <= 1'b1;
                    active        <= 1'b1;
                    busy_cnt      <= '0;
                    state         <= ARB_WAIT_BUSY;
                end

                ARB_WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= ARB_WAIT_DONE;
                    end else if (busy_cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
                        // The byte was already acked, so it is simply dropped.
                        timeout_err <= 1'b1;
                        active      <= 1'b0;
                        state       <= ARB_IDLE;
                    end else begin
                        busy_cnt <= busy_cnt + CNT_W'(1);
                    end
                end

                ARB_WAIT_DONE: begin
                    if (!tx_busy) begin
                        active <= 1'b0;
                        state  <= ARB_IDLE;
                    end
                end

                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a small transmitter model answers each launch
// with a busy window, and a transaction-level reference (round-robin pointer,
// queue of acked bytes) checks every grant and launch.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ      = 4;
    localparam int DW           = 8;
    localparam int BUSY_TIMEOUT = 4;

    logic                     clk = 1'b0;
    logic                     reset = 1'b0;
    logic [NUM_REQ-1:0]       req = '0;
    logic [NUM_REQ*DW-1:0]    req_data = '0;
    logic                     tx_busy = 1'b0;
    logic [NUM_REQ-1:0]       ack;
    logic [DW-1:0]            tx_data;
    logic                     tx_data_valid;
    logic [1:0]               grant_id;
    logic                     active;
    logic                     timeout_err;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .DATA_WIDTH   (DW),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .req_data      (req_data),
        .ack           (ack),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_busy       (tx_busy),
        .grant_id      (grant_id),
        .active        (active),
        .timeout_err   (timeout_err)
    );

    int tests_run = 0;
    int tests_failed = 0;

    int cyc = 0;
    int n_ack = 0, n_valid = 0, n_timeout = 0;
    int last_ack_cyc = -100, last_valid_cyc = -100, last_timeout_cyc = -100;
    int last_active_fall = -100, busy_fall_cyc = -100;
    logic prev_active = 1'b0;

    int model_ptr = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] valid_log[$];
    int grant_log[$];
    int wait_cnt[NUM_REQ];

    // Transmitter model: 0 = answers launches, 1 = ignores launches,
    // 2 = tx_busy driven directly by the test.
    int tx_mode = 0;
    int frame_len = 3;
    int busy_left = 0;
    bit auto_drop = 1'b1;

    // Reference round-robin rule: first requester at or after the pointer.
    function automatic int model_pick(logic [NUM_REQ-1:0] r, int p);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r[(p + i) % NUM_REQ]) return (p + i) % NUM_REQ;
        end
        return -1;
    endfunction

    // Advance one clock; observe outputs at the falling edge and run the
    // scoreboard and the transmitter model.
    task automatic cycle();
        logic [NUM_REQ-1:0]    r_e;
        logic [NUM_REQ*DW-1:0] d_e;
        int w;
        r_e = req;
        d_e = req_data;
        @(negedge clk);
        cyc++;
        if (ack !== '0) begin
            n_ack++;
            last_ack_cyc = cyc;
            w = model_pick(r_e, model_ptr);
            tests_run++;
            if (w < 0 || ack !== (4'b0001 << w)) begin
                tests_failed++;
                $display("FAIL sb_ack: ack=%b, required winner %0d (req=%b ptr=%0d)", ack, w, r_e, model_ptr);
            end
            if (w >= 0) begin
                tests_run++;
                if (grant_id !== w[1:0]) begin
                    tests_failed++;
                    $display("FAIL sb_grant_id: got %0d, required %0d", grant_id, w);
                end
                tests_run++;
                if (tx_data !== d_e[w*DW +: DW]) begin
                    tests_failed++;
                    $display("FAIL sb_tx_data_latch: got %h, required %h", tx_data, d_e[w*DW +: DW]);
                end
                tests_run++;
                if (wait_cnt[w] > NUM_REQ - 1) begin
                    tests_failed++;
                    $display("FAIL sb_fairness: requester %0d waited %0d grants, limit %0d", w, wait_cnt[w], NUM_REQ - 1);
                end
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (i != w && r_e[i]) wait_cnt[i]++;
                end
                wait_cnt[w] = 0;
                exp_q.push_back(d_e[w*DW +: DW]);
                grant_log.push_back(w);
                model_ptr = (w + 1) % NUM_REQ;
            end
            if (auto_drop) req = req & ~ack;
        end
        if (tx_data_valid === 1'b1) begin
            n_valid++;
            last_valid_cyc = cyc;
            valid_log.push_back(tx_data);
            tests_run++;
            if (exp_q.size() == 0 || tx_data !== exp_q[0]) begin
                tests_failed++;
                $display("FAIL sb_launch_byte: got %h, required %h (queue %0d)", tx_data,
                         (exp_q.size() != 0) ? exp_q[0] : 8'h00, exp_q.size());
            end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            tests_run++;
            if (last_ack_cyc != cyc - 1) begin
                tests_failed++;
                $display("FAIL sb_launch_latency: valid at %0d, ack at %0d, required ack+1", cyc, last_ack_cyc);
            end
        end
        if (timeout_err === 1'b1) begin
            n_timeout++;
            last_timeout_cyc = cyc;
        end
        if (prev_active === 1'b1 && active === 1'b0) last_active_fall = cyc;
        prev_active = active;
        if (tx_mode != 2) begin
            if (tx_mode == 0 && tx_data_valid === 1'b1 && busy_left == 0) begin
                tx_busy   = 1'b1;
                busy_left = frame_len;
            end else if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) begin
                    tx_busy       = 1'b0;
                    busy_fall_cyc = cyc;
                end
            end
        end
    endtask

    // Withdraw all requests and run until the arbiter sits quietly in idle.
    task automatic drain();
        int quiet;
        quiet = 0;
        req = '0;
        for (int i = 0; i < 200 && quiet < 4; i++) begin
            cycle();
            if (active === 1'b0 && tx_busy === 1'b0 && ack === '0 && tx_data_valid === 1'b0)
                quiet++;
            else
                quiet = 0;
        end
        tests_run++;
        if (quiet < 4) begin
            tests_failed++;
            $display("FAIL drain_idle: arbiter did not settle, active=%b busy=%b", active, tx_busy);
        end
        for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] = 0;
    endtask

    task automatic check_all_zero(string tag);
        tests_run++;
        if ({ack, tx_data, tx_data_valid, grant_id, active, timeout_err} !== '0) begin
            tests_failed++;
            $display("FAIL %s: ack=%b tx_data=%h valid=%b grant_id=%0d active=%b timeout_err=%b, required all 0",
                     tag, ack, tx_data, tx_data_valid, grant_id, active, timeout_err);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset_outputs");
        tests_run++;
        if (ack !== '0) begin
            tests_failed++;
            $display("FAIL reset_ack: got %b, required 0", ack);
        end
        reset = 1'b1;
        model_ptr = 0;
        cycle();
        check_all_zero("after_reset_idle");
    endtask

    task automatic test_round_robin_all();
        int g0, v0;
        int exp_g[5] = '{0, 1, 2, 3, 0};
        logic [DW-1:0] exp_b[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        g0 = grant_log.size();
        v0 = valid_log.size();
        auto_drop = 1'b0;
        frame_len = 3;
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        req = 4'b1111;
        for (int i = 0; i < 200 && valid_log.size() - v0 < 5; i++) cycle();
        req = '0;
        auto_drop = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (grant_log.size() <= g0 + i || grant_log[g0 + i] != exp_g[i]) begin
                tests_failed++;
                $display("FAIL rr_grant_order[%0d]: got %0d, required %0d", i,
                         (grant_log.size() > g0 + i) ? grant_log[g0 + i] : -1, exp_g[i]);
            end
            tests_run++;
            if (valid_log.size() <= v0 + i || valid_log[v0 + i] !== exp_b[i]) begin
                tests_failed++;
                $display("FAIL rr_byte_order[%0d]: got %h, required %h", i,
                         (valid_log.size() > v0 + i) ? valid_log[v0 + i] : 8'h00, exp_b[i]);
            end
        end
        drain();
    endtask

    task automatic test_single();
        int c0;
        bit hi_ok;
        frame_len = 5;
        req_data[15:8] = 8'hA5;
        req = 4'b0010;
        c0 = cyc;
        cycle();
        tests_run++;
        if (ack !== 4'b0010 || last_ack_cyc != c0 + 1) begin
            tests_failed++;
            $display("FAIL single_ack: ack=%b at %0d, required 0010 at %0d", ack, last_ack_cyc, c0 + 1);
        end
        cycle();
        tests_run++;
        if (tx_data_valid !== 1'b1 || tx_data !== 8'hA5) begin
            tests_failed++;
            $display("FAIL single_launch: valid=%b tx_data=%h, required 1/a5", tx_data_valid, tx_data);
        end
        hi_ok = 1'b1;
        for (int i = 0; i < 40 && active !== 1'b0; i++) begin
            if (tx_busy === 1'b1 && active !== 1'b1) hi_ok = 1'b0;
            cycle();
        end
        tests_run++;
        if (!hi_ok || last_active_fall != busy_fall_cyc + 1) begin
            tests_failed++;
            $display("FAIL single_active_span: active fell at %0d, busy fell at %0d, required busy+1", last_active_fall, busy_fall_cyc);
        end
        tests_run++;
        if (tx_data !== 8'hA5) begin
            tests_failed++;
            $display("FAIL single_tx_data_hold: got %h, required a5", tx_data);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int t;
        frame_len = 2;
        auto_drop = 1'b0;
        req_data[7:0]   = 8'h3C;
        req_data[23:16] = 8'hC3;
        req = 4'b0101;
        for (int i = 0; i < 10 && tx_data_valid !== 1'b1; i++) cycle();
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (active === 1'b0) break;
        end
        t = cyc;
        cycle();
        tests_run++;
        if (ack === '0 || last_ack_cyc != t + 1) begin
            tests_failed++;
            $display("FAIL b2b_ack: ack=%b at %0d, required a grant at %0d", ack, last_ack_cyc, t + 1);
        end
        cycle();
        tests_run++;
        if (tx_data_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_launch: valid=%b at %0d, required 1 at %0d", tx_data_valid, cyc, t + 2);
        end
        auto_drop = 1'b1;
        drain();
    endtask

    task automatic test_timeout();
        int cv, t0, first_w;
        tx_mode = 1;
        req_data[7:0]  = 8'h5E;
        req_data[15:8] = 8'hE5;
        req = 4'b0011;
        cv = -1;
        for (int i = 0; i < 10 && cv < 0; i++) begin
            cycle();
            if (tx_data_valid === 1'b1) cv = cyc;
        end
        first_w = (grant_log.size() != 0) ? grant_log[grant_log.size() - 1] : -1;
        t0 = n_timeout;
        for (int i = 0; i < 20 && n_timeout == t0; i++) cycle();
        tests_run++;
        if (n_timeout == t0 || last_timeout_cyc != cv + BUSY_TIMEOUT) begin
            tests_failed++;
            $display("FAIL timeout_latency: pulse at %0d, required %0d", last_timeout_cyc, cv + BUSY_TIMEOUT);
        end
        tests_run++;
        if (active !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_active: got %b, required 0", active);
        end
        tx_mode = 0;
        cycle();
        tests_run++;
        if (timeout_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_pulse_width: got %b, required 0", timeout_err);
        end
        tests_run++;
        if (ack === '0 || grant_log[grant_log.size() - 1] == first_w) begin
            tests_failed++;
            $display("FAIL timeout_next_served: ack=%b, first winner %0d", ack, first_w);
        end
        drain();
    endtask

    task automatic test_busy_in_idle();
        int a0, v0, cr;
        tx_mode = 2;
        tx_busy = 1'b1;
        req_data[23:16] = 8'h5A;
        req = 4'b0100;
        a0 = n_ack;
        v0 = n_valid;
        repeat (6) cycle();
        tests_run++;
        if (n_ack != a0 || n_valid != v0) begin
            tests_failed++;
            $display("FAIL busy_idle_hold: %0d acks, %0d launches, required none", n_ack - a0, n_valid - v0);
        end
        tx_busy = 1'b0;
        busy_left = 0;
        tx_mode = 0;
        cr = cyc;
        cycle();
        tests_run++;
        if (ack !== 4'b0100 || last_ack_cyc != cr + 1) begin
            tests_failed++;
            $display("FAIL busy_idle_release: ack=%b at %0d, required 0100 at %0d", ack, last_ack_cyc, cr + 1);
        end
        drain();
    endtask

    task automatic test_reset_mid_frame();
        frame_len = 20;
        req_data[23:16] = 8'h77;
        req = 4'b0100;
        for (int i = 0; i < 10 && !(tx_busy === 1'b1 && active === 1'b1); i++) cycle();
        cycle();
        #1;
        reset = 1'b0;
        #1;
        check_all_zero("reset_mid_frame_async");
        tx_busy = 1'b0;
        busy_left = 0;
        model_ptr = 0;
        exp_q.delete();
        for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] = 0;
        req = '0;
        cycle();
        reset = 1'b1;
        frame_len = 3;
        req_data[31:24] = 8'hC3;
        req = 4'b1000;
        cycle();
        tests_run++;
        if (ack !== 4'b1000 || grant_id !== 2'd3) begin
            tests_failed++;
            $display("FAIL reset_wrap_grant: ack=%b grant_id=%0d, required 1000/3", ack, grant_id);
        end
        drain();
    endtask

    task automatic test_random();
        int a0;
        a0 = n_ack;
        auto_drop = 1'b1;
        for (int it = 0; it < 400; it++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req_data[i*DW +: DW] = DW'($urandom);
                    req[i] = 1'b1;
                end
            end
            frame_len = $urandom_range(1, 4);
            tx_mode = ($urandom_range(0, 9) == 0) ? 1 : 0;
            cycle();
        end
        tx_mode = 0;
        drain();
        tests_run++;
        if (n_ack - a0 < 20) begin
            tests_failed++;
            $display("FAIL random_throughput: %0d grants, required at least 20", n_ack - a0);
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL random_unlaunched: %0d acked bytes never launched, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_round_robin_all();
        test_single();
        test_back_to_back();
        test_timeout();
        test_busy_in_idle();
        test_reset_mid_frame();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
